// File: rtl/serial_frame_tx.sv
// serial_frame_tx: frames a parallel word for the 1001 pattern-detector line.
// Each frame on w is preamble 1,0,0,1, then DATA_W payload bits MSB first,
// then GAP_LEN zeros so the downstream detector settles back to idle.
module serial_frame_tx #(
   parameter int DATA_W  = 8,
   parameter int GAP_LEN = 3
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              w,
   output logic              sop,
   output logic              busy
);

   // The counter is sized for the longest phase, which is at least the 4-bit preamble.
   localparam int MAX_DG   = (DATA_W > GAP_LEN) ? DATA_W : GAP_LEN;
   localparam int CNT_SPAN = (MAX_DG > 4) ? MAX_DG : 4;
   localparam int CW       = $clog2(CNT_SPAN);

   localparam logic [CW-1:0] PRE_LAST  = CW'(3);
   localparam logic [CW-1:0] PRE_BIT2  = CW'(2);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic              w_reg, w_next;
   logic              sop_reg, sop_next;
   logic              busy_reg, busy_next;

   // State, counter, payload shifter and registered line outputs.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         shift_reg <= '0;
         w_reg     <= 1'b0;
         sop_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         shift_reg <= shift_next;
         w_reg     <= w_next;
         sop_reg   <= sop_next;
         busy_reg  <= busy_next;
      end
   end

   // Next-state logic; w_next is the bit the line carries in the following cycle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      shift_next = shift_reg;
      w_next     = 1'b0;
      sop_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               shift_next = in_data;
               cnt_next   = '0;
               state_next = PRE;
               w_next     = 1'b1;          // preamble bit 0
            end
         end
         PRE: begin
            if (cnt_reg == PRE_LAST) begin
               state_next = DATA;
               cnt_next   = '0;
               w_next     = shift_reg[DATA_W-1];
               shift_next = shift_reg << 1;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
               // Preamble bits 1 and 2 are zero; bit 3 is one and is the sop cycle.
               w_next   = (cnt_reg == PRE_BIT2);
               sop_next = (cnt_reg == PRE_BIT2);
            end
         end
         DATA: begin
            if (cnt_reg == DATA_LAST) begin
               state_next = GAP;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_reg + CNT_ONE;
               w_next     = shift_reg[DATA_W-1];
               shift_next = shift_reg << 1;
            end
         end
         GAP: begin
            if (cnt_reg == GAP_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
            shift_next = '0;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   assign in_ready = (state_reg == IDLE);
   assign w        = w_reg;
   assign sop      = sop_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx with a 1001 Mealy detector on the line.
module tb_serial_frame_tx;

   logic       clock;
   logic       Reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       w;
   logic       sop;
   logic       busy;

   logic [0:0] in_data2;
   logic       in_valid2;
   logic       in_ready2;
   logic       w2;
   logic       sop2;
   logic       busy2;

   int tests;
   int fails;

   serial_frame_tx #(.DATA_W(8), .GAP_LEN(3)) dut (
      .clock(clock), .Reset(Reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .w(w), .sop(sop), .busy(busy)
   );

   serial_frame_tx #(.DATA_W(1), .GAP_LEN(5)) dut_small (
      .clock(clock), .Reset(Reset), .in_data(in_data2), .in_valid(in_valid2),
      .in_ready(in_ready2), .w(w2), .sop(sop2), .busy(busy2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference 4-state Mealy detector for 1001 (overlapping); z on the last bit.
   logic [1:0] det_state;
   logic       z;
   assign z = (det_state == 2'd3) && w;

   always @(posedge clock or negedge Reset) begin
      if (!Reset) det_state <= 2'd0;
      else begin
         case (det_state)
            2'd0: det_state <= w ? 2'd1 : 2'd0;
            2'd1: det_state <= w ? 2'd1 : 2'd2;
            2'd2: det_state <= w ? 2'd1 : 2'd3;
            default: det_state <= w ? 2'd1 : 2'd0;
         endcase
      end
   end

   typedef struct {
      string      name;
      logic [7:0] data;
      logic [14:0] exp_w;
      bit         chk_z;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present a word in the next cycle and complete the handshake on the following edge.
   task automatic start_frame(input logic [7:0] data);
      int n;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("ready before handshake", in_ready, 1);
      chk("detector idle at frame start", det_state, 0);
      in_data  = data;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_data  = ~data;
   endtask

   // Check the 15 line cycles after a handshake, then the first IDLE cycle.
   task automatic check_frame(input string name, input logic [14:0] exp, input bit chk_z);
      int errs0;
      errs0 = fails;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         chk($sformatf("%s w[%0d]", name, i), w, exp[14-i]);
         chk($sformatf("%s sop[%0d]", name, i), sop, (i == 3));
         chk($sformatf("%s busy[%0d]", name, i), busy, 1);
         chk($sformatf("%s in_ready[%0d]", name, i), in_ready, 0);
         if (chk_z) chk($sformatf("%s z[%0d]", name, i), z, sop);
      end
      @(negedge clock);
      chk($sformatf("%s in_ready after frame", name), in_ready, 1);
      chk($sformatf("%s busy after frame", name), busy, 0);
      chk($sformatf("%s w after frame", name), w, 0);
      $display("[TB] frame %s: %0d new errors", name, fails - errs0);
   endtask

   time t0, t1;

   initial begin
      tests = 0;
      fails = 0;
      vecs[0] = '{name: "A5", data: 8'hA5, exp_w: 15'b100110100101000, chk_z: 1'b0};
      vecs[1] = '{name: "00", data: 8'h00, exp_w: 15'b100100000000000, chk_z: 1'b1};
      vecs[2] = '{name: "81", data: 8'h81, exp_w: 15'b100110000001000, chk_z: 1'b1};
      vecs[3] = '{name: "5A", data: 8'h5A, exp_w: 15'b100101011010000, chk_z: 1'b1};

      Reset     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      in_data2  = 1'b0;
      in_valid2 = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset w", w, 0);
      chk("reset sop", sop, 0);
      chk("reset busy", busy, 0);
      chk("reset in_ready", in_ready, 1);
      Reset = 1'b1;

      // Single frames from the table.
      for (int k = 0; k < 4; k++) begin
         start_frame(vecs[k].data);
         check_frame(vecs[k].name, vecs[k].exp_w, vecs[k].chk_z);
      end

      // Back-to-back: FF then 00 with in_valid held; data swapped during frame 1.
      @(negedge clock);
      in_data  = 8'hFF;
      in_valid = 1'b1;
      @(posedge clock);
      t0 = $time;
      #1;
      in_data = 8'h00;
      check_frame("b2b FF", 15'b100111111111000, 1'b1);
      @(posedge clock);
      t1 = $time;
      #1;
      in_valid = 1'b0;
      in_data  = 8'h55;
      check_frame("b2b 00", 15'b100100000000000, 1'b1);
      chk("b2b frame spacing", 32'((t1 - t0) / 10), 16);

      // Asynchronous reset while sop is high.
      start_frame(8'hA5);
      repeat (4) @(negedge clock);
      chk("pre-reset sop", sop, 1);
      chk("pre-reset w", w, 1);
      #2 Reset = 1'b0;
      #1;
      chk("async reset w", w, 0);
      chk("async reset sop", sop, 0);
      chk("async reset busy", busy, 0);
      chk("async reset in_ready", in_ready, 1);
      @(negedge clock);
      Reset = 1'b1;

      // Reset in the middle of the payload, then a clean new frame.
      start_frame(8'hA5);
      repeat (8) @(negedge clock);
      chk("mid-data busy", busy, 1);
      #2 Reset = 1'b0;
      #1;
      chk("mid-data reset w", w, 0);
      chk("mid-data reset busy", busy, 0);
      chk("mid-data reset in_ready", in_ready, 1);
      repeat (2) @(negedge clock);
      Reset = 1'b1;
      start_frame(8'h3C);
      check_frame("3C after reset", 15'b100100111100000, 1'b0);

      // DATA_W=1, GAP_LEN=5 instance.
      @(negedge clock);
      chk("small in_ready", in_ready2, 1);
      in_data2  = 1'b1;
      in_valid2 = 1'b1;
      @(posedge clock);
      #1;
      in_valid2 = 1'b0;
      in_data2  = 1'b0;
      begin
         logic [9:0] exp2;
         exp2 = 10'b1001100000;
         for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("small w[%0d]", i), w2, exp2[9-i]);
            chk($sformatf("small sop[%0d]", i), sop2, (i == 3));
            chk($sformatf("small busy[%0d]", i), busy2, 1);
         end
      end
      @(negedge clock);
      chk("small in_ready after frame", in_ready2, 1);
      chk("small busy after frame", busy2, 0);
      $display("[TB] frame small DATA_W=1 done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
